// File: rtl/dir_input_queue_if.sv
// Direction handoff between the input queue and game_path.
// The producer drives the head entry and valid; the consumer drives ready.
interface dir_input_queue_if;
    logic [1:0] dir_out;
    logic       dir_valid;
    logic       dir_ready;

    modport master (output dir_out, output dir_valid, input dir_ready);
    modport slave  (input dir_out, input dir_valid, output dir_ready);
endinterface

// File: rtl/dir_input_queue.sv
// Debounced pushbutton direction queue: sync, debounce, edge detect, filter, 2-entry FIFO.
// Latency DEBOUNCE_CYCLES+3 edges from key_n low to dir_valid; head pops on dir_valid & dir_ready.
// Backpressure: a full queue with no same-cycle pop drops the event and pulses ovf_pulse.
module dir_input_queue #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          key_n,
    input  logic [1:0]          cur_dir,
    dir_input_queue_if.master   dq,
    output logic [1:0]          count,
    output logic                rej_pulse,
    output logic                ovf_pulse
);
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1, sync2;
    logic [3:0] deb, deb_d, evt;
    logic [7:0] db_cnt [4];

    logic [1:0] q0, q1, cnt;
    logic       pop, has_evt, bad, accept, push, ovf;
    logic [1:0] cnt_after, evt_dir, ref_dir;

    // Debounced level is stored active-high (1 = pressed); synchronizers hold raw active-low key_n.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
            deb   <= 4'h0;
            deb_d <= 4'h0;
            evt   <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= 8'd0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            deb_d <= deb;
            evt   <= deb & ~deb_d;
            for (int i = 0; i < 4; i++) begin
                if (~sync2[i] == deb[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= 8'd0;
                    deb[i]    <= ~deb[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Key bit index equals its direction code, so priority is simply highest set bit.
    always_comb begin
        evt_dir = 2'd0;
        if (evt[3])      evt_dir = 2'd3;
        else if (evt[2]) evt_dir = 2'd2;
        else if (evt[1]) evt_dir = 2'd1;
        else             evt_dir = 2'd0;
    end

    always_comb begin
        pop       = dq.dir_ready && (cnt != 2'd0);
        cnt_after = cnt - {1'b0, pop};
        has_evt   = |evt;
        if (cnt_after == 2'd0)  ref_dir = cur_dir;
        else if (cnt == 2'd2)   ref_dir = q1;
        else                    ref_dir = q0;
        bad       = (evt_dir == ref_dir) || (evt_dir == ~ref_dir);
        accept    = has_evt && !bad;
        push      = accept && (cnt_after != 2'd2);
        ovf       = accept && (cnt_after == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q0        <= 2'd0;
            q1        <= 2'd0;
            cnt       <= 2'd0;
            rej_pulse <= 1'b0;
            ovf_pulse <= 1'b0;
        end else begin
            if (pop) q0 <= q1;
            if (push) begin
                if (cnt_after == 2'd0) q0 <= evt_dir;
                else                   q1 <= evt_dir;
            end
            cnt       <= cnt_after + {1'b0, push};
            rej_pulse <= has_evt && bad;
            ovf_pulse <= ovf;
        end
    end

    assign dq.dir_valid = (cnt != 2'd0);
    assign dq.dir_out   = (cnt != 2'd0) ? q0 : 2'd0;
    assign count        = cnt;
endmodule

// File: tb/tb_dir_input_queue.sv
// Randomized and directed bench for dir_input_queue against a queue-based reference model.
module tb_dir_input_queue;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [1:0] cur_dir = 2'd0;
    logic [1:0] count;
    logic       rej_pulse, ovf_pulse;

    dir_input_queue_if dq ();

    dir_input_queue #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .cur_dir(cur_dir),
        .dq(dq), .count(count), .rej_pulse(rej_pulse), .ovf_pulse(ovf_pulse)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rej_seen = 0;
    int ovf_seen = 0;

    // Reference model: pressed levels, mismatch run lengths, pending events and a queue.
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
    bit         m_deb [4];
    int         m_run [4];
    logic [3:0] m_p1 = 4'h0, m_p2 = 4'h0;
    logic [1:0] mq [$];
    bit         m_rej = 0, m_ovf = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] rose;
        logic [1:0] d, rf;
        rose  = 4'h0;
        m_rej = 0;
        m_ovf = 0;
        if (rst) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_p1 = 4'h0; m_p2 = 4'h0;
            for (int i = 0; i < 4; i++) begin m_deb[i] = 0; m_run[i] = 0; end
            mq.delete();
            return;
        end
        if (dq.dir_ready && mq.size() > 0) void'(mq.pop_front());
        if (m_p2 != 4'h0) begin
            d = 2'd0;
            for (int i = 0; i < 4; i++) if (m_p2[i]) d = 2'(i);
            rf = (mq.size() > 0) ? mq[mq.size()-1] : cur_dir;
            if (d == rf || d == ~rf) m_rej = 1;
            else if (mq.size() < 2)  mq.push_back(d);
            else                     m_ovf = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (bit'(~m_s2[i]) == m_deb[i]) m_run[i] = 0;
            else m_run[i]++;
            if (m_run[i] == D) begin
                m_deb[i] = !m_deb[i];
                m_run[i] = 0;
                if (m_deb[i]) rose[i] = 1'b1;
            end
        end
        m_p2 = m_p1;
        m_p1 = rose;
        m_s2 = m_s1;
        m_s1 = key_n;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("count", int'(count), mq.size());
        chk("dir_valid", int'(dq.dir_valid), int'(mq.size() > 0));
        chk("dir_out", int'(dq.dir_out), (mq.size() > 0) ? int'(mq[0]) : 0);
        chk("rej_pulse", int'(rej_pulse), int'(m_rej));
        chk("ovf_pulse", int'(ovf_pulse), int'(m_ovf));
        if (rej_pulse) rej_seen++;
        if (ovf_pulse) ovf_seen++;
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        key_n = k;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press(input logic [3:0] k);
        hold(k, 8);
        hold(4'hF, 8);
    endtask

    task automatic drain();
        key_n = 4'hF;
        dq.dir_ready = 1'b1;
        hold(4'hF, 4);
        dq.dir_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin m_deb[i] = 0; m_run[i] = 0; end
        dq.dir_ready = 1'b0;
        rst = 1'b1;
        hold(4'hF, 2);
        chk("reset_count", int'(count), 0);
        chk("reset_valid", int'(dq.dir_valid), 0);
        rst = 1'b0;

        // Single DOWN press held long: one entry, no pulse on release
        hold(4'b1101, 12);
        hold(4'hF, 10);
        chk("down_count", int'(count), 1);
        chk("down_dir", int'(dq.dir_out), 1);
        drain();

        // Glitch shorter than the debounce window
        hold(4'b1101, 3);
        hold(4'hF, 10);
        chk("glitch_count", int'(count), 0);

        // Reversal then duplicate against cur_dir RIGHT
        rej_seen = 0;
        press(4'b0111);
        press(4'b1110);
        chk("rej_count", rej_seen, 2);
        chk("rej_qcount", int'(count), 0);

        // Fill and overflow, then drain in order
        ovf_seen = 0;
        press(4'b1101);
        press(4'b0111);
        press(4'b1011);
        chk("full_count", int'(count), 2);
        chk("ovf_once", ovf_seen, 1);
        dq.dir_ready = 1'b1;
        cycle();
        chk("pop1_dir", int'(dq.dir_out), 3);
        cycle();
        chk("pop2_valid", int'(dq.dir_valid), 0);
        dq.dir_ready = 1'b0;

        // Full queue with pop in the same cycle as an UP event
        press(4'b1101);
        press(4'b0111);
        key_n = 4'b1011;
        for (int i = 0; i < 12; i++) begin
            dq.dir_ready = (m_p2 != 4'h0);
            cycle();
        end
        dq.dir_ready = 1'b0;
        chk("popush_count", int'(count), 2);
        chk("popush_head", int'(dq.dir_out), 3);

        // Reset with full queue and UP mid-debounce, UP held through reset
        hold(4'hF, 8);
        hold(4'b1011, 3);
        rst = 1'b1;
        cycle();
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(dq.dir_valid), 0);
        rst = 1'b0;
        hold(4'b1011, 10);
        chk("rst_up_dir", int'(dq.dir_out), 2);
        drain();

        // Random segments: held key patterns, random ready, occasional heading change and reset
        for (int s = 0; s < 400; s++) begin
            key_n = 4'($urandom);
            if ($urandom_range(0, 3) == 0) key_n = 4'hF;
            if ($urandom_range(0, 7) == 0) cur_dir = 2'($urandom);
            rst = ($urandom_range(0, 60) == 0);
            for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
                dq.dir_ready = ($urandom_range(0, 3) == 0);
                cycle();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dir_input_queue.md
DIR_INPUT_QUEUE -- requirements
Module: dir_input_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst, as in the rest of the codebase.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles a key level must hold before the debounced level changes; legal range 1..255.
REQ-003 clk  input  1  system clock (50 MHz); all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 key_n  input  4  raw pushbuttons, active-low, asynchronous: bit3 LEFT, bit2 UP, bit1 DOWN, bit0 RIGHT.
REQ-006 cur_dir  input  2  current snake heading from game_path.
REQ-007 dir_ready  input  1  game_path pops the head entry in any cycle where dir_ready and dir_valid are both high.
REQ-008 dir_out  output  2  head-of-queue direction; encoding 00 RIGHT, 01 DOWN, 10 UP, 11 LEFT.
REQ-009 dir_valid  output  1  queue is non-empty.
REQ-010 count  output  2  queue occupancy, 0..2.
REQ-011 rej_pulse  output  1  one-cycle pulse when a press event is rejected as a duplicate or reversal.
REQ-012 ovf_pulse  output  1  one-cycle pulse when a press event is dropped because the queue is full.

Function
REQ-013 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-014 Each key SHALL have an independent debounce counter.
  - Counter clears whenever the synchronized level equals the debounced level.
  - The debounced level toggles after DEBOUNCE_CYCLES consecutive cycles of mismatch.
REQ-015 A press event SHALL be a debounced released-to-pressed transition. Release transitions generate no event.
REQ-016 Latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges: key_n first sampled low at edge N gives dir_valid high after edge N+DEBOUNCE_CYCLES+3, provided the queue was empty and the event is accepted.
REQ-017 If several press events occur in the same cycle, only one SHALL be considered, priority LEFT > UP > DOWN > RIGHT; the others are discarded silently.
REQ-018 Reference direction for checking an event:
  - the newest queued entry (tail) if count > 0 after any same-cycle pop, otherwise cur_dir.
  - If the queue empties by a same-cycle pop, cur_dir is the reference.
REQ-019 An event SHALL be rejected, with rej_pulse for one cycle, if its direction equals the reference or equals the bitwise inverse of the reference (the reversal).
REQ-020 The queue SHALL be a 2-entry FIFO. dir_out always shows the oldest entry; dir_out is 00 when empty.
REQ-021 An unrejected event with count==2 and no same-cycle pop SHALL be dropped, with ovf_pulse for one cycle; queue contents are unchanged.
REQ-022 Simultaneous pop and push:
  - Both SHALL occur in that cycle, and count is unchanged.
  - This also applies when count==2: the push is accepted because the pop frees a slot.
REQ-023 A pop with dir_valid low SHALL be ignored, and count SHALL never underflow.
REQ-024 All outputs SHALL be registered or decoded directly from registers, with no combinational path from key_n, cur_dir or dir_ready to any output.
REQ-025 rej_pulse and ovf_pulse SHALL be asserted in the cycle after the event is evaluated and SHALL never be high together.

Reset
REQ-026 While rst is high:
  - The queue SHALL be emptied.
  - count=0, dir_valid=0, dir_out=00, rej_pulse=0, ovf_pulse=0.
  - All debounced levels SHALL be released, and all counters and synchronizer flops cleared to the released state.
REQ-027 Reset SHALL take priority over any same-cycle push or pop. An in-flight debounce SHALL be abandoned.
REQ-028 A key held through reset SHALL produce one press event DEBOUNCE_CYCLES+3 cycles after the first edge with rst low.

Verification (DEBOUNCE_CYCLES=4, cur_dir=00 unless stated)
REQ-029 DOWN held low 12 cycles, dir_ready=0 -> exactly 7 edges later dir_valid=1, dir_out=01, count=1; one entry only; no pulse on release.
REQ-030 DOWN low for 3 cycles, then high -> no event; count stays 0; no pulses.
REQ-031 Press LEFT, then press RIGHT -> each is rejected with one rej_pulse; count=0.
REQ-032 Press DOWN, then LEFT, then UP, dir_ready=0 -> count=2 and ovf_pulse once; then dir_ready=1 pops 01, then 11, then dir_valid=0.
REQ-033 count=2 (DOWN, LEFT) and an UP event in the same cycle dir_ready=1 -> UP is accepted (reference is the tail LEFT); count=2; dir_out=11.
REQ-034 rst asserted with count=2 and UP mid-debounce -> next cycle count=0, dir_valid=0; with UP still held after rst drops, the event appears 7 edges later as dir_out=10.
